// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared state, stage-mask types and stage ordering for the layer sequencer
package cnn_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_FC,
    S_RELU,
    S_MAXP,
    S_SFMAX,
    S_NEXT
  } seq_state_t;

  typedef struct packed {
    logic conv;
    logic fc;
    logic relu;
    logic maxp;
    logic sfmax;
  } stage_mask_t;

  function automatic logic is_stage(input seq_state_t s);
    return (s != S_IDLE) && (s != S_NEXT);
  endfunction

  // First enabled stage strictly after cur; IDLE/NEXT mean "start of a layer".
  function automatic seq_state_t next_stage(input seq_state_t cur, input stage_mask_t m);
    logic at_start, upto_relu, upto_maxp, upto_sfmax;
    seq_state_t ns;
    at_start   = (cur == S_IDLE) || (cur == S_NEXT);
    upto_relu  = at_start || (cur == S_CONV) || (cur == S_FC);
    upto_maxp  = upto_relu || (cur == S_RELU);
    upto_sfmax = upto_maxp || (cur == S_MAXP);
    if (at_start && m.conv)          ns = S_CONV;
    else if (at_start && m.fc)       ns = S_FC;
    else if (upto_relu && m.relu)    ns = S_RELU;
    else if (upto_maxp && m.maxp)    ns = S_MAXP;
    else if (upto_sfmax && m.sfmax)  ns = S_SFMAX;
    else                             ns = S_NEXT;
    return ns;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage cycle watchdog; expired flags the LIMIT-th cycle in a stage
module stage_watchdog #(
  parameter int unsigned LIMIT = cnn_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of completed cycles in the current stage, saturating at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (LIMIT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - walks a latched per-layer stage program, pulsing engine starts
module layer_sequencer
  import cnn_pkg::*;
#(
  parameter int          NUM_LAYERS     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int         LW             = $clog2(NUM_LAYERS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LW-1:0]         num_layers,
  input  logic [NUM_LAYERS-1:0] conv_en,
  input  logic [NUM_LAYERS-1:0] relu_en,
  input  logic [NUM_LAYERS-1:0] maxp_en,
  input  logic [NUM_LAYERS-1:0] fc_en,
  input  logic [NUM_LAYERS-1:0] sfmax_en,
  input  logic                  conv_done,
  input  logic                  relu_done,
  input  logic                  maxp_done,
  input  logic                  fc_done,
  input  logic                  sfmax_done,
  output logic                  conv_run,
  output logic                  relu_run,
  output logic                  maxp_run,
  output logic                  fc_run,
  output logic                  sfmax_run,
  output logic [LW-1:0]         layer_idx,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  err,
  output logic [LW-1:0]         err_layer
);

  seq_state_t state, state_next;

  logic [LW-1:0]         count_q, layer_q, layer_next, err_layer_next, start_count;
  logic [LW:0]           layer_plus1;
  logic [NUM_LAYERS-1:0] conv_q, relu_q, maxp_q, fc_q, sfmax_q;
  stage_mask_t           cur_mask, nxt_mask, start_mask;
  logic                  err_next, seq_done_next, latch_cfg;
  logic                  enter, in_stage, first_cycle, done_sel, wd_expired, last_layer;

  function automatic stage_mask_t mask_at(
    input logic [NUM_LAYERS-1:0] c, input logic [NUM_LAYERS-1:0] f,
    input logic [NUM_LAYERS-1:0] r, input logic [NUM_LAYERS-1:0] m,
    input logic [NUM_LAYERS-1:0] s, input logic [LW-1:0] idx);
    logic [NUM_LAYERS-1:0] cs, fs, rs, ms, ss;
    cs = c >> idx;
    fs = f >> idx;
    rs = r >> idx;
    ms = m >> idx;
    ss = s >> idx;
    return '{conv: cs[0], fc: fs[0], relu: rs[0], maxp: ms[0], sfmax: ss[0]};
  endfunction

  assign start_count = (num_layers > LW'(NUM_LAYERS)) ? LW'(NUM_LAYERS) : num_layers;
  assign start_mask  = '{conv: conv_en[0], fc: fc_en[0], relu: relu_en[0],
                         maxp: maxp_en[0], sfmax: sfmax_en[0]};
  assign layer_plus1 = {1'b0, layer_q} + (LW+1)'(1);
  assign last_layer  = (count_q == '0) || (layer_plus1 >= {1'b0, count_q});
  assign cur_mask    = mask_at(conv_q, fc_q, relu_q, maxp_q, sfmax_q, layer_q);
  assign nxt_mask    = mask_at(conv_q, fc_q, relu_q, maxp_q, sfmax_q, layer_plus1[LW-1:0]);

  // A run pulse is present only in a stage's first cycle; done is ignored there.
  assign first_cycle = conv_run | fc_run | relu_run | maxp_run | sfmax_run;
  assign in_stage    = is_stage(state);

  always_comb begin
    done_sel = 1'b0;
    case (state)
      S_CONV:  done_sel = conv_done;
      S_FC:    done_sel = fc_done;
      S_RELU:  done_sel = relu_done;
      S_MAXP:  done_sel = maxp_done;
      S_SFMAX: done_sel = sfmax_done;
      default: done_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state;
    layer_next     = layer_q;
    err_next       = err;
    err_layer_next = err_layer;
    seq_done_next  = 1'b0;
    latch_cfg      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_cfg  = 1'b1;
          err_next   = 1'b0;
          layer_next = '0;
          state_next = (start_count == '0) ? S_NEXT : next_stage(S_IDLE, start_mask);
        end
      end
      S_NEXT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (last_layer) begin
          state_next    = S_IDLE;
          seq_done_next = 1'b1;
        end else begin
          layer_next = layer_plus1[LW-1:0];
          state_next = next_stage(S_NEXT, nxt_mask);
        end
      end
      default: begin
        // abort outranks done, which outranks the watchdog
        if (abort) begin
          state_next = S_IDLE;
        end else if (done_sel && !first_cycle) begin
          state_next = next_stage(state, cur_mask);
        end else if (wd_expired) begin
          state_next     = S_IDLE;
          err_next       = 1'b1;
          err_layer_next = layer_q;
        end
      end
    endcase
  end

  assign enter = is_stage(state_next) && (state_next != state);

  stage_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (enter),
    .enable (in_stage),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count_q   <= '0;
      layer_q   <= '0;
      conv_q    <= '0;
      fc_q      <= '0;
      relu_q    <= '0;
      maxp_q    <= '0;
      sfmax_q   <= '0;
      err       <= 1'b0;
      err_layer <= '0;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
      conv_run  <= 1'b0;
      fc_run    <= 1'b0;
      relu_run  <= 1'b0;
      maxp_run  <= 1'b0;
      sfmax_run <= 1'b0;
    end else begin
      state     <= state_next;
      layer_q   <= layer_next;
      err       <= err_next;
      err_layer <= err_layer_next;
      busy      <= (state_next != S_IDLE);
      seq_done  <= seq_done_next;
      conv_run  <= enter && (state_next == S_CONV);
      fc_run    <= enter && (state_next == S_FC);
      relu_run  <= enter && (state_next == S_RELU);
      maxp_run  <= enter && (state_next == S_MAXP);
      sfmax_run <= enter && (state_next == S_SFMAX);
      if (latch_cfg) begin
        count_q <= start_count;
        conv_q  <= conv_en;
        fc_q    <= fc_en;
        relu_q  <= relu_en;
        maxp_q  <= maxp_en;
        sfmax_q <= sfmax_en;
      end
    end
  end

  assign layer_idx = layer_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized self-checking bench for layer_sequencer
module tb_layer_sequencer;

  localparam int NL = 4;
  localparam int TO = 8;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [LW-1:0] num_layers = '0;
  logic [NL-1:0] conv_en = '0, relu_en = '0, maxp_en = '0, fc_en = '0, sfmax_en = '0;
  logic conv_done = 1'b0, relu_done = 1'b0, maxp_done = 1'b0, fc_done = 1'b0, sfmax_done = 1'b0;
  logic conv_run, relu_run, maxp_run, fc_run, sfmax_run;
  logic [LW-1:0] layer_idx, err_layer;
  logic busy, seq_done, err;
  logic [4:0] runs;

  int vectors = 0;
  int miscompares = 0;

  // step codes: 0 conv, 1 fc, 2 relu, 3 maxp, 4 sfmax, 5 layer boundary, 6 completion
  typedef struct {
    int code;
    int layer;
  } step_t;
  step_t steps[$];

  always #5 clk = ~clk;

  assign runs = {sfmax_run, maxp_run, relu_run, fc_run, conv_run};

  layer_sequencer #(
    .NUM_LAYERS(NL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_layers(num_layers),
    .conv_en(conv_en), .relu_en(relu_en), .maxp_en(maxp_en), .fc_en(fc_en), .sfmax_en(sfmax_en),
    .conv_done(conv_done), .relu_done(relu_done), .maxp_done(maxp_done), .fc_done(fc_done),
    .sfmax_done(sfmax_done), .conv_run(conv_run), .relu_run(relu_run), .maxp_run(maxp_run),
    .fc_run(fc_run), .sfmax_run(sfmax_run), .layer_idx(layer_idx), .busy(busy),
    .seq_done(seq_done), .err(err), .err_layer(err_layer)
  );

  function automatic logic bit_at(input logic [NL-1:0] v, input int l);
    logic [NL-1:0] s;
    s = v >> l;
    return s[0];
  endfunction

  // Expected program: per layer, primary (conv over fc), relu, maxp, sfmax, then a boundary cycle.
  task automatic build_steps(input int n, input logic [NL-1:0] cm, input logic [NL-1:0] fm,
                             input logic [NL-1:0] rm, input logic [NL-1:0] mm,
                             input logic [NL-1:0] sm);
    int eff;
    eff = (n > NL) ? NL : n;
    steps.delete();
    for (int l = 0; l < eff; l++) begin
      if (bit_at(cm, l))      steps.push_back('{0, l});
      else if (bit_at(fm, l)) steps.push_back('{1, l});
      if (bit_at(rm, l))      steps.push_back('{2, l});
      if (bit_at(mm, l))      steps.push_back('{3, l});
      if (bit_at(sm, l))      steps.push_back('{4, l});
      steps.push_back('{5, l});
    end
    if (eff == 0) steps.push_back('{5, 0});
    steps.push_back('{6, 0});
  endtask

  task automatic drive_dones(input int match, input logic val, input bit perturb);
    logic [4:0] v;
    v = perturb ? 5'($urandom_range(0, 31)) : 5'd0;
    if (match >= 0) v = (v & ~(5'd1 << match)) | (5'(val) << match);
    {sfmax_done, maxp_done, relu_done, fc_done, conv_done} = v;
    start = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
    if (perturb) begin
      num_layers = LW'($urandom);
      conv_en    = NL'($urandom);
      fc_en      = NL'($urandom);
      relu_en    = NL'($urandom);
      maxp_en    = NL'($urandom);
      sfmax_en   = NL'($urandom);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the seq_done cycle.
  task automatic run_program(input logic [LW-1:0] n, input logic [NL-1:0] cm,
                             input logic [NL-1:0] fm, input logic [NL-1:0] rm,
                             input logic [NL-1:0] mm, input logic [NL-1:0] sm,
                             input int fixed_d, input bit perturb, input string tag);
    int d;
    int code;
    logic [4:0] exp_run;
    build_steps(int'(n), cm, fm, rm, mm, sm);
    num_layers = n; conv_en = cm; fc_en = fm; relu_en = rm; maxp_en = mm; sfmax_en = sm;
    drive_dones(-1, 1'b0, 1'b0);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    foreach (steps[i]) begin
      code = steps[i].code;
      exp_run = (code < 5) ? 5'(1 << code) : 5'd0;
      vectors++;
      if (runs !== exp_run || busy !== (code != 6) || seq_done !== (code == 6) || err !== 1'b0) begin
        miscompares++;
        $display("FAIL %s step %0d: run=%b busy=%b seq_done=%b err=%b, expected run=%b busy=%b seq_done=%b err=0",
                 tag, i, runs, busy, seq_done, err, exp_run, code != 6, code == 6);
      end
      if (code != 6) begin
        vectors++;
        if (layer_idx !== LW'(steps[i].layer)) begin
          miscompares++;
          $display("FAIL %s step %0d layer_idx: got %0d expected %0d", tag, i, layer_idx, steps[i].layer);
        end
      end
      if (code < 5) begin
        d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, TO - 1));
        drive_dones(code, perturb ? 1'($urandom_range(0, 1)) : 1'b0, perturb);
        for (int k = 1; k <= d; k++) begin
          @(negedge clk);
          vectors++;
          if (runs !== 5'd0 || busy !== 1'b1 || seq_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wait step %0d cycle %0d: run=%b busy=%b seq_done=%b, expected run=00000 busy=1 seq_done=0",
                     tag, i, k, runs, busy, seq_done);
          end
          drive_dones(code, k == d, perturb);
        end
        @(negedge clk);
      end else if (code == 5) begin
        drive_dones(-1, 1'b0, perturb);
        @(negedge clk);
      end else begin
        drive_dones(-1, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({runs, busy, seq_done, err} !== 8'd0 || layer_idx !== '0 || err_layer !== '0) begin
      miscompares++;
      $display("FAIL reset: run=%b busy=%b seq_done=%b err=%b layer_idx=%0d err_layer=%0d, expected all zero",
               runs, busy, seq_done, err, layer_idx, err_layer);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_layer();
    run_program(3'd2, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 3, 1'b0, "two_layer");
    @(negedge clk);
  endtask

  task automatic test_fc_chain();
    run_program(3'd1, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 1'b0, "fc_chain");
    @(negedge clk);
    run_program(3'd1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 1'b0, "conv_over_fc");
    @(negedge clk);
  endtask

  task automatic test_empty();
    run_program(3'd0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 0, 1'b0, "zero_layers");
    @(negedge clk);
    run_program(3'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, "empty_masks");
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    num_layers = 3'd2; conv_en = 4'b0011; fc_en = '0; relu_en = '0; maxp_en = '0; sfmax_en = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (runs !== 5'b00001 || layer_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL wd_first_run: run=%b layer=%0d expected 00001 layer 0", runs, layer_idx);
    end
    @(negedge clk);
    @(negedge clk);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (runs !== 5'b00001 || layer_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL wd_second_run: run=%b layer=%0d expected 00001 layer 1", runs, layer_idx);
    end
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      vectors++;
      if (k < TO && (err !== 1'b0 || busy !== 1'b1)) begin
        miscompares++;
        $display("FAIL wd_early cycle %0d: err=%b busy=%b expected err=0 busy=1", k, err, busy);
      end else if (k == TO && (err !== 1'b1 || err_layer !== 3'd1 || busy !== 1'b0 || seq_done !== 1'b0)) begin
        miscompares++;
        $display("FAIL wd_expire: err=%b err_layer=%0d busy=%b seq_done=%b expected 1 1 0 0",
                 err, err_layer, busy, seq_done);
      end
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (err !== 1'b1 || seq_done !== 1'b0 || busy !== 1'b0 || runs !== 5'd0) begin
        miscompares++;
        $display("FAIL wd_sticky: err=%b seq_done=%b busy=%b run=%b expected 1 0 0 00000",
                 err, seq_done, busy, runs);
      end
    end
    run_program(3'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0, "wd_err_clear");
    @(negedge clk);
  endtask

  task automatic test_abort();
    num_layers = 3'd1; conv_en = '0; fc_en = '0; relu_en = 4'b0001; maxp_en = 4'b0001; sfmax_en = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (runs !== 5'b00100) begin
      miscompares++;
      $display("FAIL abort_relu_run: run=%b expected 00100", runs);
    end
    @(negedge clk);
    @(negedge clk);
    relu_done = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    relu_done = 1'b0;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || runs !== 5'd0 || seq_done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_stop: busy=%b run=%b seq_done=%b err=%b expected 0 00000 0 0", busy, runs, seq_done, err);
    end
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || runs !== 5'd0 || seq_done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet: busy=%b run=%b seq_done=%b expected 0 00000 0", busy, runs, seq_done);
      end
    end
    num_layers = 3'd0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b1 || seq_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle_busy: busy=%b seq_done=%b expected 1 0", busy, seq_done);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || seq_done !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle_done: busy=%b seq_done=%b expected 0 1", busy, seq_done);
    end
    @(negedge clk);
  endtask

  task automatic test_perturbed();
    for (int r = 0; r < 6; r++) begin
      run_program(LW'($urandom_range(1, 4)), NL'($urandom), NL'($urandom), NL'($urandom),
                  NL'($urandom), NL'($urandom), 0, 1'b1, "perturbed");
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      run_program(LW'($urandom_range(0, 7)), NL'($urandom), NL'($urandom), NL'($urandom),
                  NL'($urandom), NL'($urandom), 0, 1'b0, "random");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_program(3'd2, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 0, 1'b0, "b2b_first");
    run_program(3'd3, 4'b0000, 4'b0101, 4'b0111, 4'b0100, 4'b0000, 0, 1'b0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    num_layers = 3'd2; conv_en = 4'b0011; fc_en = '0; relu_en = 4'b0011; maxp_en = '0; sfmax_en = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || runs !== 5'd0 || seq_done !== 1'b0 || layer_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_midrun: busy=%b run=%b seq_done=%b layer=%0d expected all zero",
               busy, runs, seq_done, layer_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || runs !== 5'd0 || seq_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_quiet: busy=%b run=%b seq_done=%b expected 0 00000 0", busy, runs, seq_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_layer();
    test_fc_chain();
    test_empty();
    test_watchdog();
    test_abort();
    test_back_to_back();
    test_perturbed();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 32: maximum number of layers in a network program.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: per-stage watchdog limit in cycles; 0 disables the watchdog.
REQ-003 Localparam LW = $clog2(NUM_LAYERS+1): width of the layer count and layer index.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  begin program; sampled only in IDLE.
REQ-007 abort  in  1  terminate the run immediately.
REQ-008 num_layers  in  LW  layers to execute; values above NUM_LAYERS clamp to NUM_LAYERS.
REQ-009 conv_en, relu_en, maxp_en, fc_en, sfmax_en  in  NUM_LAYERS each  per-layer stage enables; bit i applies to layer i.
REQ-010 conv_done, relu_done, maxp_done, fc_done, sfmax_done  in  1 each  engine completion pulses.
REQ-011 conv_run, relu_run, maxp_run, fc_run, sfmax_run  out  1 each  single-cycle engine start pulses.
REQ-012 layer_idx  out  LW  index of the current layer.
REQ-013 busy  out  1  program in progress.
REQ-014 seq_done  out  1  single-cycle pulse on normal completion.
REQ-015 err  out  1  sticky watchdog-timeout flag.
REQ-016 err_layer  out  LW  layer index at timeout.

Function
REQ-017 States: IDLE, CONV, FC, RELU, MAXP, SFMAX, NEXT. All outputs are registered.
REQ-018 start in IDLE: latch num_layers (clamped) and all five masks; later input changes do not affect the run. Clear err and set layer_idx=0.
REQ-019 Per-layer stage order: primary stage CONV if conv_en, else FC if fc_en; then RELU, MAXP, SFMAX, each only if enabled. conv_en and fc_en both set: CONV runs and FC is skipped.
REQ-020 On entry to a stage state, the matching run_* is high for exactly that first cycle; no other run_* is high in that cycle.
REQ-021 done_* is accepted on any cycle after the run pulse while in the matching state. done asserted in the run-pulse cycle, or in a non-matching state, is ignored.
REQ-022 Done accepted at cycle N: the next enabled stage's state and run pulse occur at cycle N+1. If no further stage is enabled, the sequencer is in NEXT at cycle N+1.
REQ-023 NEXT lasts 1 cycle. If layer_idx == latched count-1: go to IDLE, busy=0, seq_done=1 for that cycle. Otherwise increment layer_idx and dispatch the next layer's first enabled stage.
REQ-024 A layer with no stages enabled passes through NEXT only; it costs 1 cycle.
REQ-025 start with num_layers=0: busy is high for 1 cycle (NEXT), then seq_done pulses; no run_* is issued.
REQ-026 start while busy is ignored.
REQ-027 Watchdog counts cycles in the current stage and resets on every stage entry. At count == TIMEOUT_CYCLES with no done: err=1, err_layer=layer_idx, go to IDLE, busy=0, no seq_done.
REQ-028 abort in any non-IDLE state: IDLE next cycle, busy=0, no seq_done, err unchanged. abort in IDLE has no effect.
REQ-029 Simultaneous events: abort beats done and timeout; done beats timeout in the same cycle.

Reset
REQ-030 rst_n low: state=IDLE, all run_*=0, busy=0, seq_done=0, err=0, err_layer=0, layer_idx=0, watchdog=0, latched config=0.
REQ-031 Reset mid-run aborts with no seq_done pulse; engines are not notified.

Structure
REQ-032 Shared package cnn_pkg holds the seq_state_t enum, the stage_mask_t struct (five enable bits), and the default TIMEOUT_CYCLES constant.
REQ-033 The watchdog is sub-module stage_watchdog (clear, enable, expired), instantiated once.

Verification
REQ-034 NUM_LAYERS=4, num_layers=2, conv/relu/maxp_en=4'b0011, done 3 cycles after each run: run order conv,relu,maxp,conv,relu,maxp; layer_idx 0→1; one seq_done.
REQ-035 Layer 0 fc_en=1, maxp_en=1, sfmax_en=1, num_layers=1: fc_run, maxp_run, sfmax_run in that order; each run exactly 1 cycle after the previous done.
REQ-036 TIMEOUT_CYCLES=8, conv_done withheld: err=1 and err_layer=0 exactly 8 cycles after conv_run; busy=0; no seq_done. Next start clears err.
REQ-037 abort asserted in RELU together with relu_done: IDLE next cycle, no maxp_run, no seq_done.
REQ-038 num_layers=0, and a separate run with all masks zero and num_layers=3: no run_*; seq_done 1 and 3 cycles after start respectively.
REQ-039 Masks changed mid-run, start pulsed while busy, stray maxp_done in CONV: behaviour identical to the unperturbed run.
